mod_n_counter_sync: RTL
=======================

Name: mod_n_counter_sync

Overview:
- Fully synchronous, parametrised modulus-N counter built from DIGITS cascaded mod-N digits, so it covers BCD for N=10 and base-N for any N.
- Adds features the async mod-5 ripple counter lacks: up/down counting, enable, parallel load, wrap or saturate mode, and a carry output for chaining.
- Intended for timers, prescalers and display counters inside the single-clock domain.

Parameters:
- N, 5, modulus per digit; must be >= 2.
- DIGITS, 1, number of cascaded digits; must be >= 1.
- MODE, MODE_WRAP, overflow behaviour; type mode_e from the package: MODE_WRAP or MODE_SATURATE.
- WRAP_CNT_W, 8, width of the wrap counter; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous functional clear.
- en_i  in  1  count enable.
- up_i  in  1  direction: 1 = up, 0 = down.
- load_i  in  1  synchronous parallel load.
- load_val_i  in  DIGITS*W  load value; W = $clog2(N); digit k occupies [k*W +: W].
- count_o  out  DIGITS*W  current count, registered, same packing as load_val_i.
- tc_o  out  1  terminal count, combinational: every digit is at N-1 (up_i=1) or at 0 (up_i=0).
- carry_o  out  1  tc_o & en_i & ~load_i & ~clear_i; cascade enable for a following counter.
- wrap_o  out  1  registered one-cycle pulse on the cycle after the counter wraps.

Behaviour:
- Reset: rst_i=1 at a clock edge sets count_o=0, wrap_o=0 and the wrap count to 0. Reset overrides everything, including a reset asserted mid-count or mid-load.
- Priority per edge: rst_i > clear_i > load_i > en_i.
- clear_i: same effect as reset on count_o, wrap_o and the wrap count.
- load_i: each digit takes its load_val_i field on the next edge. A field >= N is clamped to N-1. wrap_o=0 that cycle. en_i is ignored.
- Counting (en_i=1, no higher-priority input): digit 0 steps every cycle. Digit k steps only when all lower digits are at their terminal value for the current direction.
- Step rule: up goes N-1 -> 0, otherwise +1. Down goes 0 -> N-1, otherwise -1.
- Direction change: up_i is sampled every cycle; there is no pipeline, so a direction change takes effect on the same edge.
- Full-counter boundary in MODE_WRAP: when tc_o & en_i, all digits roll over (up: all to 0; down: all to N-1) and wrap_o=1 for exactly the next cycle.
- Full-counter boundary in MODE_SATURATE: when tc_o & en_i, count_o holds and wrap_o stays 0. The counter leaves saturation only by reversing direction, load, clear or reset.
- en_i=0: count holds; wrap_o=0 on the next cycle.
- Latency: count_o updates 1 cycle after the qualifying edge. tc_o and carry_o are combinational from count_o and the inputs.
- count_o never holds a digit value >= N, in either mode.

Optional Feature:
- Macro: MOD_N_COUNTER_SYNC_WRAP_CNT_EN.
- With the macro defined: extra output wrap_cnt_o [WRAP_CNT_W-1:0] counts wrap events. It increments whenever wrap_o is set, saturates at all-ones, and is cleared by rst_i, clear_i or load_i.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mod_n_counter_pkg holds:
  - mode_e enum (MODE_WRAP, MODE_SATURATE);
  - a function computing digit width from N;
  - a function step_digit(val, up, n) returning the next digit value.
- Sub-module mod_n_digit: one W-bit digit register with clear, load with clamp, and step_en/up inputs. It outputs its value and a terminal flag.
- The top instantiates DIGITS copies via generate, ANDs the terminal flags into the step enables, and owns wrap_o, the mode logic and the optional wrap counter.

Test Plan (N=5, DIGITS=2, W=3 unless stated):
- Reset then en_i=1, up_i=1 for 25 cycles: count_o steps 00,01..04,10..44 with fields as base-5 digits. On cycle 25 count_o=00, and wrap_o=1 for exactly one cycle.
- Load 0x24 (fields 4,4) then en_i=1, up_i=0: next edge count_o fields (4,3); tc_o=0. After reaching 00, tc_o=1, and the next edge gives 44 with wrap_o=1.
- Load field value 7 into digit 0: count_o digit 0 reads 4 (clamped). Assert load_i and clear_i together: clear wins, count_o=0.
- MODE_SATURATE, count up to 44 and hold en_i=1 for 5 cycles: count_o stays 44, wrap_o stays 0, carry_o=1. Set up_i=0: next edge gives 43.
- Assert rst_i mid-count at 32: next edge count_o=0, wrap_o=0. With the macro defined, wrap_cnt_o=0 after 3 wraps and a reset, and reads 3 after 3 wraps without reset.
- N=10, DIGITS=3: 1000 enabled cycles from 0 return to 000 with exactly one wrap_o pulse, and count_o never shows a digit > 9.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared types and helpers for the synchronous modulus-N counter.
package mod_n_counter_pkg;

  typedef enum logic [0:0] {MODE_WRAP, MODE_SATURATE} mode_e;

  // A modulus of 2 still needs one bit.
  function automatic int unsigned digit_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned step_digit(int unsigned val, logic up, int unsigned n);
    if (up) begin
      return (val >= n - 1) ? 0 : val + 1;
    end
    return (val == 0) ? n - 1 : val - 1;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulus-N digit: synchronous reset/clear, clamped parallel load, up/down step.
module mod_n_digit
  import mod_n_counter_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned W = digit_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_en_i,
  input  logic         up_i,
  output logic [W-1:0] val_o,
  output logic         term_o
);

  localparam logic [W-1:0] MaxVal = W'(N - 1);

  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clear_i) begin
      val_d = '0;
    end else if (load_i) begin
      val_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (step_en_i) begin
      val_d = W'(step_digit(int'(val_q), up_i, N));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o  = val_q;
  assign term_o = up_i ? (val_q == MaxVal) : (val_q == '0);

endmodule

// File: rtl/mod_n_counter_sync.sv
// Cascaded modulus-N up/down counter with wrap/saturate mode and carry output.
// Define MOD_N_COUNTER_SYNC_WRAP_CNT_EN to add the wrap_cnt_o event counter.
module mod_n_counter_sync
  import mod_n_counter_pkg::*;
#(
  parameter int unsigned N          = 5,
  parameter int unsigned DIGITS     = 1,
  parameter mode_e       MODE       = MODE_WRAP,
  parameter int unsigned WRAP_CNT_W = 8,
  localparam int unsigned W         = digit_width(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  load_i,
  input  logic [DIGITS*W-1:0]   load_val_i,
  output logic [DIGITS*W-1:0]   count_o,
  output logic                  tc_o,
  output logic                  carry_o,
`ifdef MOD_N_COUNTER_SYNC_WRAP_CNT_EN
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o,
`endif
  output logic                  wrap_o
);

  if (N < 2) begin : g_bad_n
    $error("mod_n_counter_sync: N must be >= 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("mod_n_counter_sync: DIGITS must be >= 1");
  end
  if (WRAP_CNT_W < 1) begin : g_bad_wrap_cnt_w
    $error("mod_n_counter_sync: WRAP_CNT_W must be >= 1");
  end

  logic [DIGITS-1:0] term;
  // chain[k] is set when every digit below k sits at its terminal value.
  logic [DIGITS:0]   chain;
  logic              tc;
  logic              step_en;
  logic              wrap_q, wrap_d;

  assign chain[0] = 1'b1;
  assign tc       = chain[DIGITS];
  // A saturating counter at its boundary simply stops stepping.
  assign step_en  = en_i & ~((MODE == MODE_SATURATE) & tc);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [W-1:0] val;

    mod_n_digit #(
      .N (N),
      .W (W)
    ) u_digit (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .load_i     (load_i),
      .load_val_i (load_val_i[k*W +: W]),
      .step_en_i  (step_en & chain[k]),
      .up_i       (up_i),
      .val_o      (val),
      .term_o     (term[k])
    );

    assign chain[k+1]        = chain[k] & term[k];
    assign count_o[k*W +: W] = val;
  end

  always_comb begin
    wrap_d = 1'b0;
    if (!clear_i && !load_i && en_i && tc && (MODE == MODE_WRAP)) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o  = wrap_q;
  assign tc_o    = tc;
  assign carry_o = tc & en_i & ~load_i & ~clear_i;

`ifdef MOD_N_COUNTER_SYNC_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // Counts on the same edge that raises wrap_o, so both update together.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clear_i || load_i) begin
      wrap_cnt_d = '0;
    end else if (wrap_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt_o = wrap_cnt_q;
`endif

endmodule
